// File: rtl/pht_update_queue.sv
// pht_update_queue
// ----------------
// Buffers resolved conditional-branch outcomes and retires them one per cycle
// as read-modify-write updates of the gshare pattern history table (PHT).
//
// Pipeline:
//   S0  head of the FIFO issues a PHT read when phtRdGrant is high (popped)
//   S1  counter returned on phtRdData (or forwarded) is incremented/decremented
//   WR  write register driving the PHT write port for exactly one cycle
//   W2  copy of the previous cycle's WR, covering the write that committed
//       in the same cycle the S1 entry's read was performed
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   brValid/brPC/brGHR/
//   brTaken / brReady        branch-outcome enqueue interface
//   phtRdGrant               PHT read port free this cycle
//   phtRdEn/phtRdIndex       update-side PHT read request (phtRdEn is combinational)
//   phtRdData                PHT counter, valid the cycle after phtRdEn
//   phtWrEn/phtWrIndex/
//   phtWrData                PHT write port
//   count                    occupied FIFO entries
//   busy                     FIFO non-empty or an update still in flight
module pht_update_queue #(
    parameter int DEPTH           = 4,
    parameter int PHT_INDEX_WIDTH = 10,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       brValid,
    input  logic [ADDR_WIDTH-1:0]      brPC,
    input  logic [PHT_INDEX_WIDTH-1:0] brGHR,
    input  logic                       brTaken,
    output logic                       brReady,
    input  logic                       phtRdGrant,
    output logic                       phtRdEn,
    output logic [PHT_INDEX_WIDTH-1:0] phtRdIndex,
    input  logic [1:0]                 phtRdData,
    output logic                       phtWrEn,
    output logic [PHT_INDEX_WIDTH-1:0] phtWrIndex,
    output logic [1:0]                 phtWrData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PHT_INDEX_WIDTH-1:0] index_t;

    typedef struct packed {
        index_t index;
        logic   taken;
    } entry_t;

    // ------------------------------------------------------------------
    // FIFO storage and control
    // ------------------------------------------------------------------
    entry_t            queue_mem [DEPTH];
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  occupancy;

    logic              head_valid;
    logic              push;
    logic              pop;
    entry_t            push_entry;

    // Only the PC bits above the instruction-alignment bits feed the hash.
    logic              unused_pc_bits;
    assign unused_pc_bits = ^{brPC[ADDR_WIDTH-1:PHT_INDEX_WIDTH+2], brPC[1:0]};

    assign push_entry.index = brPC[PHT_INDEX_WIDTH+1:2] ^ brGHR;
    assign push_entry.taken = brTaken;

    assign head_valid = (occupancy != '0);
    assign brReady    = (occupancy < CNT_W'(DEPTH));
    assign push       = brValid && brReady;
    assign pop        = head_valid && phtRdGrant;

    assign phtRdEn    = pop;
    // Idle read index is held at zero rather than showing stale slot data.
    assign phtRdIndex = head_valid ? queue_mem[head_ptr].index : '0;
    assign count      = occupancy;

    // NOTE: the storage array carries no reset; occupancy and the pointers
    // define which slots are meaningful, so clearing data would only cost
    // reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[tail_ptr] <= push_entry;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            occupancy <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow wraps naturally.
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // S1: counter arithmetic with forwarding from WR and W2
    // ------------------------------------------------------------------
    logic   s1_valid;
    index_t s1_index;
    logic   s1_taken;

    logic   wr_valid;
    index_t wr_index;
    logic [1:0] wr_data;

    logic   w2_valid;
    index_t w2_index;
    logic [1:0] w2_data;

    logic [1:0] old_ctr;
    logic [1:0] new_ctr;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        old_ctr = phtRdData;
        // WR is younger than W2: it is the value about to land in the array.
        if (wr_valid && (wr_index == s1_index)) begin
            old_ctr = wr_data;
        end else if (w2_valid && (w2_index == s1_index)) begin
            // The read for this entry happened in the cycle W2 was being
            // written, so the array returned the value from before it.
            old_ctr = w2_data;
        end

        new_ctr = old_ctr;
        if (s1_taken) begin
            if (old_ctr != 2'd3) new_ctr = old_ctr + 2'd1;
        end else begin
            if (old_ctr != 2'd0) new_ctr = old_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_index <= '0;
            s1_taken <= 1'b0;
            wr_valid <= 1'b0;
            wr_index <= '0;
            wr_data  <= '0;
            w2_valid <= 1'b0;
            w2_index <= '0;
            w2_data  <= '0;
        end else begin
            s1_valid <= pop;
            if (pop) begin
                s1_index <= queue_mem[head_ptr].index;
                s1_taken <= queue_mem[head_ptr].taken;
            end

            // A valid S1 produces exactly one write-cycle in WR.
            wr_valid <= s1_valid;
            if (s1_valid) begin
                wr_index <= s1_index;
                wr_data  <= new_ctr;
            end

            w2_valid <= wr_valid;
            w2_index <= wr_index;
            w2_data  <= wr_data;
        end
    end

    assign phtWrEn    = wr_valid;
    assign phtWrIndex = wr_index;
    assign phtWrData  = wr_data;

    assign busy = head_valid || s1_valid || wr_valid;

endmodule
